// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states and
// stream framing constants.
package imem_loader_pkg;

    localparam int HDR_LEN        = 2;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_CNT_HI = 3'd0,
        ST_CNT_LO = 3'd1,
        ST_DATA   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

endpackage

// File: rtl/imem_loader_word_packer.sv
// Collects big-endian stream bytes into 32-bit words; word_done marks the
// accepting cycle of the 4th byte, with word presenting the completed value.
module word_packer
    import imem_loader_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic        word_done
);

    logic [1:0]  idx;
    logic [23:0] sr;

    // The final byte is merged combinationally so the top can register the
    // complete word on the same edge that accepts it.
    assign word      = {sr, byte_in};
    assign word_done = shift_en && (idx == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            idx <= '0;
            sr  <= '0;
        end else if (clear) begin
            idx <= '0;
            sr  <= '0;
        end else if (shift_en) begin
            idx <= idx + 2'd1;
            sr  <= {sr[15:0], byte_in};
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses count/data/checksum byte stream, writes IM words 0..N-1
// and releases the CPU from reset only after the checksum matches.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              load_req,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_reset_n,
    output logic              load_done,
    output logic              load_err
);

    // state     | meaning
    // ST_CNT_HI | waiting for word count high byte
    // ST_CNT_LO | waiting for word count low byte, range check
    // ST_DATA   | collecting data bytes, one IM write per 4 bytes
    // ST_CHECK  | waiting for XOR checksum byte
    // ST_DONE   | image verified, CPU released
    // ST_ERROR  | oversize count or bad checksum, CPU held

    state_t          state;
    logic [15:0]     n_words;
    logic [ADDR_W:0] word_cnt;
    logic [7:0]      csum;

    logic        xfer;
    logic        terminal;
    logic        pk_clear;
    logic        pk_shift;
    logic        word_done;
    logic [31:0] word;
    logic [15:0] n_full;
    logic        last_word;

    assign xfer      = byte_valid && byte_ready;
    assign terminal  = (state == ST_DONE) || (state == ST_ERROR);
    assign pk_clear  = terminal && load_req;
    assign pk_shift  = xfer && (state == ST_DATA);
    assign n_full    = {n_words[15:8], byte_data};
    assign last_word = ((16'(word_cnt) + 16'd1) == n_words);

    word_packer u_packer (
        .Clk       (Clk),
        .Reset     (Reset),
        .clear     (pk_clear),
        .shift_en  (pk_shift),
        .byte_in   (byte_data),
        .word      (word),
        .word_done (word_done)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= ST_CNT_HI;
            n_words     <= '0;
            word_cnt    <= '0;
            csum        <= '0;
            byte_ready  <= 1'b1;
            im_we       <= 1'b0;
            im_addr     <= '0;
            im_wdata    <= '0;
            cpu_reset_n <= 1'b0;
            load_done   <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            im_we <= 1'b0;
            case (state)
                ST_CNT_HI: begin
                    if (xfer) begin
                        n_words[15:8] <= byte_data;
                        state         <= ST_CNT_LO;
                    end
                end
                ST_CNT_LO: begin
                    if (xfer) begin
                        n_words[7:0] <= byte_data;
                        if (n_full > 16'(DEPTH)) begin
                            state      <= ST_ERROR;
                            byte_ready <= 1'b0;
                            load_err   <= 1'b1;
                        end else if (n_full == 16'd0) begin
                            state <= ST_CHECK;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (xfer) begin
                        csum <= csum ^ byte_data;
                        if (word_done) begin
                            im_we    <= 1'b1;
                            im_addr  <= word_cnt[ADDR_W-1:0];
                            im_wdata <= word;
                            word_cnt <= word_cnt + 1'b1;
                            if (last_word) begin
                                state <= ST_CHECK;
                            end
                        end
                    end
                end
                ST_CHECK: begin
                    if (xfer) begin
                        byte_ready <= 1'b0;
                        if (byte_data == csum) begin
                            state       <= ST_DONE;
                            cpu_reset_n <= 1'b1;
                            load_done   <= 1'b1;
                        end else begin
                            state    <= ST_ERROR;
                            load_err <= 1'b1;
                        end
                    end
                end
                ST_DONE, ST_ERROR: begin
                    if (load_req) begin
                        state       <= ST_CNT_HI;
                        byte_ready  <= 1'b1;
                        cpu_reset_n <= 1'b0;
                        load_done   <= 1'b0;
                        load_err    <= 1'b0;
                        csum        <= '0;
                        word_cnt    <= '0;
                        n_words     <= '0;
                    end
                end
                default: begin
                    state <= ST_CNT_HI;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: expected IM writes are queued
// from an image-level model and matched by an independent write monitor.
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    typedef logic [7:0] byteq_t[$];
    typedef logic [31:0] wordq_t[$];

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        int                cyc;
    } wr_t;

    logic              Clk = 1'b0;
    logic              Reset = 1'b0;
    logic              load_req = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'h00;
    logic              byte_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_reset_n;
    logic              load_done;
    logic              load_err;

    int  vectors = 0;
    int  errors  = 0;
    int  cyc     = 0;
    wr_t sb[$];
    bit  exp_done;
    bit  exp_err;

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .load_req    (load_req),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .im_we       (im_we),
        .im_addr     (im_addr),
        .im_wdata    (im_wdata),
        .cpu_reset_n (cpu_reset_n),
        .load_done   (load_done),
        .load_err    (load_err)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Write monitor: every IM strobe must match the oldest expected write.
    always @(negedge Clk) begin
        #2;
        if (Reset && im_we) begin
            vectors++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL im_write: unexpected write addr %h data %h", im_addr, im_wdata);
            end else begin
                wr_t e;
                e = sb.pop_front();
                if (im_addr !== e.addr || im_wdata !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL im_write: got addr %h data %h cyc %0d expected addr %h data %h cyc %0d",
                             im_addr, im_wdata, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    function automatic byteq_t build(input wordq_t w, input bit bad);
        byteq_t s;
        logic [7:0] x;
        logic [15:0] n;
        x = 8'h00;
        n = 16'(w.size());
        s.push_back(n[15:8]);
        s.push_back(n[7:0]);
        foreach (w[i]) begin
            for (int b = 3; b >= 0; b--) begin
                logic [31:0] wv;
                wv = w[i];
                s.push_back(wv[b*8 +: 8]);
                x ^= wv[b*8 +: 8];
            end
        end
        s.push_back(bad ? ~x : x);
        return s;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int drop, input bit noise,
                             output bit acc, output int k);
        int tries;
        bit rdy;
        tries = 0;
        acc = 0;
        k = 0;
        while (drop > 0 && $urandom_range(99) < drop) begin
            byte_valid = 1'b0;
            load_req = noise && ($urandom_range(7) == 0);
            @(negedge Clk);
        end
        load_req = 1'b0;
        byte_valid = 1'b1;
        byte_data = b;
        while (!acc && tries < 20) begin
            rdy = byte_ready;
            @(posedge Clk);
            #1;
            k = cyc;
            @(negedge Clk);
            if (rdy) acc = 1;
            else tries++;
        end
        byte_valid = 1'b0;
        if (!acc) begin
            vectors++;
            errors++;
            $display("FAIL byte_accept: byte %h not accepted within 20 cycles", b);
        end
    endtask

    // Feeds a stream; the model derives writes and final status from the
    // image itself. abort_after > 0 stops after that many accepted bytes.
    task automatic send_stream(input byteq_t s, input int drop, input bit noise, input int abort_after);
        logic [15:0] n;
        logic [7:0]  x;
        logic [31:0] w;
        bit          acc;
        int          k;
        n = {s[0], s[1]};
        x = 8'h00;
        w = 32'h0;
        for (int j = 0; j < s.size(); j++) begin
            send_byte(s[j], drop, noise, acc, k);
            if (!acc) return;
            if (j >= 2 && n <= 16'(DEPTH) && j < 2 + 4 * int'(n)) begin
                x ^= s[j];
                w = {w[23:0], s[j]};
                if ((j - 2) % 4 == 3) begin
                    wr_t e;
                    e.addr = ADDR_W'((j - 2) / 4);
                    e.data = w;
                    e.cyc  = k;
                    sb.push_back(e);
                end
            end
            if (abort_after == j + 1) return;
        end
        if (n > 16'(DEPTH)) begin
            exp_done = 0;
            exp_err  = 1;
        end else begin
            exp_done = (s[s.size() - 1] == x);
            exp_err  = !exp_done;
        end
        chk("load_done", 32'(load_done), 32'(exp_done));
        chk("load_err", 32'(load_err), 32'(exp_err));
        chk("cpu_reset_n", 32'(cpu_reset_n), 32'(exp_done));
        chk("byte_ready_end", 32'(byte_ready), 32'd0);
    endtask

    task automatic restart();
        repeat (2) @(negedge Clk);
        chk("hold_done", 32'(load_done), 32'(exp_done));
        chk("hold_cpu_reset_n", 32'(cpu_reset_n), 32'(exp_done));
        chk("hold_err", 32'(load_err), 32'(exp_err));
        load_req = 1'b1;
        @(negedge Clk);
        load_req = 1'b0;
        chk("req_cpu_reset_n", 32'(cpu_reset_n), 32'd0);
        chk("req_byte_ready", 32'(byte_ready), 32'd1);
        chk("req_done", 32'(load_done), 32'd0);
        chk("req_err", 32'(load_err), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_byte_ready"}, 32'(byte_ready), 32'd1);
        chk({tag, "_im_we"}, 32'(im_we), 32'd0);
        chk({tag, "_im_addr"}, 32'(im_addr), 32'd0);
        chk({tag, "_im_wdata"}, im_wdata, 32'd0);
        chk({tag, "_cpu_reset_n"}, 32'(cpu_reset_n), 32'd0);
        chk({tag, "_load_done"}, 32'(load_done), 32'd0);
        chk({tag, "_load_err"}, 32'(load_err), 32'd0);
    endtask

    initial begin
        byteq_t s;
        wordq_t w;
        int     timeout;

        repeat (2) @(negedge Clk);
        check_reset_values("rst");
        Reset = 1'b1;
        @(negedge Clk);

        s = '{8'h00, 8'h01, 8'h3c, 8'h10, 8'hff, 8'hff, 8'h2c};
        send_stream(s, 0, 0, 0);
        restart();

        w = '{32'h20100001, 32'h3c10ffff};
        send_stream(build(w, 0), 0, 0, 0);
        restart();

        s = '{8'h00, 8'h01, 8'h3c, 8'h10, 8'hff, 8'hff, 8'h00};
        send_stream(s, 0, 0, 0);
        restart();

        s = '{8'h01, 8'h01};
        send_stream(s, 0, 0, 0);
        restart();

        s = '{8'h00, 8'h00, 8'h00};
        send_stream(s, 0, 0, 0);
        restart();

        send_stream(build(w, 0), 40, 1, 0);
        restart();

        for (int it = 0; it < 10; it++) begin
            wordq_t rw;
            int nw;
            nw = (it == 3) ? 0 : int'($urandom_range(1, 6));
            rw = {};
            for (int i = 0; i < nw; i++) rw.push_back($urandom);
            send_stream(build(rw, $urandom_range(3) == 0), 25, 1, 0);
            restart();
        end

        send_stream(build(w, 0), 0, 0, 5);
        #3;
        Reset = 1'b0;
        #1;
        check_reset_values("midrst");
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);

        s = '{8'h00, 8'h01, 8'h3c, 8'h10, 8'hff, 8'hff, 8'h2c};
        send_stream(s, 0, 0, 0);

        timeout = 0;
        while (sb.size() != 0 && timeout < 20) begin
            @(negedge Clk);
            timeout++;
        end
        chk("pending_writes", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
